// File: rtl/pwm_v3_pkg.sv
// rtl/pwm_v3_pkg.sv - shared register map, mode enum and bit positions for pwm_multi_v3
package pwm_v3_pkg;

  localparam int ADDR_PERIOD = 0;
  localparam int ADDR_CTRL   = 1;
  localparam int ADDR_STATUS = 2;
  localparam int ADDR_POL    = 3;
  localparam int ADDR_DUTY0  = 4;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;
  localparam int CTRL_LOAD_BIT = 2;

  localparam int STAT_DOWN_BIT = 30;
  localparam int STAT_PEND_BIT = 31;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTRE = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_v3_channel.sv
// rtl/pwm_v3_channel.sv - one PWM channel: shadow/active duty, compare, polarity, output register
module pwm_v3_channel
  import pwm_v3_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_duty,
  input  logic             load,
  input  logic             enable,
  input  logic             down,
  input  logic [CNT_W-1:0] cnt,
  input  logic             pol,
  output logic [CNT_W-1:0] duty_shadow,
  output logic             pwm_out
);

  logic [CNT_W-1:0] duty_active;
  logic             raw;

  // The down phase uses <= so the high time is symmetric around the period start.
  always_comb begin
    raw = 1'b0;
    if (enable) begin
      if (down) raw = (cnt <= duty_active);
      else      raw = (cnt <  duty_active);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      duty_shadow <= '0;
      duty_active <= '0;
      pwm_out     <= 1'b0;
    end else begin
      if (wr_en) duty_shadow <= wr_duty;
      if (load)  duty_active <= wr_en ? wr_duty : duty_shadow;
      pwm_out <= raw ^ pol;
    end
  end

endmodule

// File: rtl/pwm_multi_v3.sv
// rtl/pwm_multi_v3.sv - multi-channel PWM with shadowed period/duty, edge/centre modes and register bus
module pwm_multi_v3
  import pwm_v3_pkg::*;
#(
  parameter int CH_NUM = 8,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = $clog2(CH_NUM + 4)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cs,
  input  logic              wr_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic [CH_NUM-1:0] pwm_out,
  output logic              period_tick
);

  logic             wr_en;
  logic             rd_en;
  logic [CNT_W-1:0] wdat;
  logic             unused_wr_bits;

  assign wr_en          = cs & ~wr_n;
  assign rd_en          = cs & wr_n;
  assign wdat           = wr_data[CNT_W-1:0];
  assign unused_wr_bits = ^wr_data;

  logic [CNT_W-1:0]  period_shadow;
  logic [CNT_W-1:0]  period_active;
  logic [CNT_W-1:0]  period_next;
  logic              enable;
  logic              pending;
  pwm_mode_e         mode_shadow;
  pwm_mode_e         mode_active;
  pwm_mode_e         mode_next;
  pwm_mode_e         mode_eff;
  logic [CH_NUM-1:0] polarity;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_adv;
  logic             down;
  logic             down_adv;
  logic             wrap;

  logic              wr_period;
  logic              wr_ctrl;
  logic              wr_pol;
  logic [CH_NUM-1:0] wr_duty;
  logic              force_load;
  logic              load;

  logic [CNT_W-1:0] duty_shadow [CH_NUM];
  logic [31:0]      rd_mux;

  assign wr_period  = wr_en && (addr == ADDR_W'(ADDR_PERIOD));
  assign wr_ctrl    = wr_en && (addr == ADDR_W'(ADDR_CTRL));
  assign wr_pol     = wr_en && (addr == ADDR_W'(ADDR_POL));
  assign force_load = wr_ctrl && wr_data[CTRL_LOAD_BIT];

  // A write landing on the load edge goes straight into the active copy.
  assign period_next = wr_period ? wdat : period_shadow;
  assign mode_next   = wr_ctrl ? pwm_mode_e'(wr_data[CTRL_MODE_BIT]) : mode_shadow;
  assign load        = !enable || force_load || wrap;
  assign mode_eff    = load ? mode_next : mode_active;

  // Next counter position under the currently active period and mode.
  always_comb begin
    cnt_adv  = cnt;
    down_adv = 1'b0;
    wrap     = 1'b0;
    if (period_active == '0) begin
      cnt_adv = '0;
      wrap    = 1'b1;
    end else if (mode_active == PWM_EDGE) begin
      if (cnt >= period_active) begin
        cnt_adv = '0;
        wrap    = 1'b1;
      end else begin
        cnt_adv = cnt + CNT_W'(1);
      end
    end else if (!down) begin
      if (cnt >= period_active - CNT_W'(1)) begin
        cnt_adv  = period_active;
        down_adv = 1'b1;
      end else begin
        cnt_adv = cnt + CNT_W'(1);
      end
    end else begin
      if (cnt <= CNT_W'(1)) begin
        cnt_adv = '0;
        wrap    = 1'b1;
      end else begin
        cnt_adv  = cnt - CNT_W'(1);
        down_adv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      period_shadow <= '0;
      period_active <= '0;
      enable        <= 1'b0;
      mode_shadow   <= PWM_EDGE;
      mode_active   <= PWM_EDGE;
      polarity      <= '0;
      pending       <= 1'b0;
      cnt           <= '0;
      down          <= 1'b0;
      period_tick   <= 1'b0;
    end else begin
      if (wr_period) period_shadow <= wdat;
      if (wr_ctrl) begin
        enable      <= wr_data[CTRL_EN_BIT];
        mode_shadow <= pwm_mode_e'(wr_data[CTRL_MODE_BIT]);
      end
      if (wr_pol) polarity <= wr_data[CH_NUM-1:0];

      if (load) begin
        period_active <= period_next;
        mode_active   <= mode_next;
      end

      if (load)                        pending <= 1'b0;
      else if (wr_period || |wr_duty) pending <= 1'b1;

      // Forced reloads that leave the counter beyond the new limit restart the period.
      if (!enable) begin
        cnt  <= '0;
        down <= 1'b0;
      end else if (force_load && (cnt_adv > period_next)) begin
        cnt  <= '0;
        down <= 1'b0;
      end else begin
        cnt  <= cnt_adv;
        down <= down_adv && (mode_eff == PWM_CENTRE);
      end

      period_tick <= enable && (cnt == '0) && !down;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign wr_duty[g] = wr_en && (addr == ADDR_W'(ADDR_DUTY0 + g));

    pwm_v3_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .clr        (clr),
      .wr_en      (wr_duty[g]),
      .wr_duty    (wdat),
      .load       (load),
      .enable     (enable),
      .down       (down),
      .cnt        (cnt),
      .pol        (polarity[g]),
      .duty_shadow(duty_shadow[g]),
      .pwm_out    (pwm_out[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (addr == ADDR_W'(ADDR_PERIOD)) begin
      rd_mux = 32'(period_shadow);
    end else if (addr == ADDR_W'(ADDR_CTRL)) begin
      rd_mux[CTRL_EN_BIT]   = enable;
      rd_mux[CTRL_MODE_BIT] = mode_shadow;
    end else if (addr == ADDR_W'(ADDR_STATUS)) begin
      rd_mux                = 32'(cnt);
      rd_mux[STAT_DOWN_BIT] = down;
      rd_mux[STAT_PEND_BIT] = pending;
    end else if (addr == ADDR_W'(ADDR_POL)) begin
      rd_mux = 32'(polarity);
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (addr == ADDR_W'(ADDR_DUTY0 + i)) rd_mux = 32'(duty_shadow[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_pwm_multi_v3.sv
// tb/tb_pwm_multi_v3.sv - scoreboard bench for pwm_multi_v3
module tb_pwm_multi_v3;

  localparam int CH_NUM = 8;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic              cs;
  logic              wr_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic [CH_NUM-1:0] pwm_out;
  logic              period_tick;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          hi_cnt[CH_NUM];
  int          tick_cnt;
  int          hi;

  always #5 clk = ~clk;

  pwm_multi_v3 #(
    .CH_NUM(CH_NUM),
    .CNT_W (CNT_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .cs         (cs),
    .wr_n       (wr_n),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .pwm_out    (pwm_out),
    .period_tick(period_tick)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    check_val(tag, got, exp_q.pop_front());
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cs = 1'b1; wr_n = 1'b0; addr = ADDR_W'(a); wr_data = d;
    @(negedge clk);
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic rd(input int a, input logic [31:0] e, input string tag);
    cs = 1'b1; wr_n = 1'b1; addr = ADDR_W'(a);
    exp_q.push_back(e);
    @(negedge clk);
    cs = 1'b0;
    sb_pop(tag, rd_data);
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (!period_tick && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(period_tick), 32'd1);
  endtask

  task automatic count_window(input int n);
    for (int c = 0; c < CH_NUM; c++) hi_cnt[c] = 0;
    tick_cnt = 0;
    repeat (n) begin
      for (int c = 0; c < CH_NUM; c++) hi_cnt[c] += int'(pwm_out[c]);
      tick_cnt += int'(period_tick);
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; cs = 1'b0; wr_n = 1'b1; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check_val("rst_pwm", 32'(pwm_out), 32'h0);
    check_val("rst_tick", 32'(period_tick), 32'h0);
    check_val("rst_rd", rd_data, 32'h0);
    clr = 1'b0;
    rd(2, 32'h0, "rst_status");
    rd(1, 32'h0, "rst_ctrl");

    // Full-width edge period.
    wr(0, 32'hFFFF); wr(4, 32'h1234); wr(11, 32'hFFFF); wr(1, 32'h1);
    wait_tick("e16_tick0");
    exp_q.push_back(32'h1234); exp_q.push_back(32'hFFFF); exp_q.push_back(32'd1);
    count_window(65536);
    sb_pop("e16_ch0_hi", hi_cnt[0]);
    sb_pop("e16_ch7_hi", hi_cnt[7]);
    sb_pop("e16_ticks", tick_cnt);
    check_val("e16_tick_next", 32'(period_tick), 32'd1);
    rd(0, 32'hFFFF, "period_rb");

    // Period 1: duty 0, 1 and saturated duty.
    wr(1, 32'h0); wr(0, 32'h1); wr(4, 32'h0); wr(5, 32'h1); wr(6, 32'h2); wr(1, 32'h1);
    wait_tick("p1_tick0");
    exp_q.push_back(32'd0); exp_q.push_back(32'd2); exp_q.push_back(32'd4); exp_q.push_back(32'd2);
    count_window(4);
    sb_pop("p1_ch0_hi", hi_cnt[0]);
    sb_pop("p1_ch1_hi", hi_cnt[1]);
    sb_pop("p1_ch2_hi", hi_cnt[2]);
    sb_pop("p1_ticks", tick_cnt);

    // Centre mode, period 10.
    wr(1, 32'h0); wr(0, 32'd10); wr(7, 32'd4); wr(1, 32'h3);
    wait_tick("c_tick0");
    rd(2, 32'h0000_0001, "c_status_up");
    idle(8);
    rd(2, 32'h4000_000A, "c_status_down");
    wait_tick("c_tick1");
    exp_q.push_back(32'd4); exp_q.push_back(32'd4); exp_q.push_back(32'd1);
    count_window(10);
    sb_pop("c_ch3_up_hi", hi_cnt[3]);
    count_window(10);
    sb_pop("c_ch3_down_hi", hi_cnt[3]);
    sb_pop("c_tick_next", 32'(period_tick));
    rd(1, 32'h3, "ctrl_rb");

    // Shadowed duty update mid-period, then a forced load.
    wr(1, 32'h0); wr(0, 32'd100); wr(4, 32'd10); wr(1, 32'h1);
    wait_tick("sh_tick0");
    hi = 0;
    exp_q.push_back(32'd1);
    for (int i = 0; i < 101; i++) begin
      hi += int'(pwm_out[0]);
      if (i == 29) begin
        cs = 1'b1; wr_n = 1'b0; addr = 4'd4; wr_data = 32'd50;
      end else if (i == 30) begin
        wr_n = 1'b1; addr = 4'd2;
      end else if (i == 31) begin
        cs = 1'b0;
        sb_pop("sh_pending", 32'(rd_data[31]));
      end
      @(negedge clk);
    end
    exp_q.push_back(32'd10); exp_q.push_back(32'd1); exp_q.push_back(32'd50);
    sb_pop("sh_old_duty_hi", hi);
    sb_pop("sh_tick1", 32'(period_tick));
    count_window(101);
    sb_pop("sh_new_duty_hi", hi_cnt[0]);
    hi = 0;
    for (int i = 0; i < 101; i++) begin
      hi += int'(pwm_out[0]);
      if (i == 29) begin
        cs = 1'b1; wr_n = 1'b0; addr = 4'd4; wr_data = 32'd20;
      end else if (i == 30) begin
        addr = 4'd1; wr_data = 32'h5;
      end else if (i == 31) begin
        cs = 1'b0; wr_n = 1'b1;
        check_val("fl_last_old", 32'(pwm_out[0]), 32'd1);
      end else if (i == 32) begin
        check_val("fl_applied", 32'(pwm_out[0]), 32'd0);
      end
      @(negedge clk);
    end
    exp_q.push_back(32'd32); exp_q.push_back(32'd20);
    sb_pop("fl_period_hi", hi);
    count_window(101);
    sb_pop("fl_next_hi", hi_cnt[0]);
    rd(2, 32'h0000_0001, "fl_status_clear");

    // Polarity while disabled, then reset mid-period.
    wr(1, 32'h0); wr(3, 32'h1);
    idle(1);
    check_val("pol_disabled", 32'(pwm_out), 32'h01);
    wr(1, 32'h1);
    idle(40);
    rd(0, 32'd100, "period_rb2");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("clr_pwm", 32'(pwm_out), 32'h0);
    check_val("clr_tick", 32'(period_tick), 32'h0);
    check_val("clr_rd", rd_data, 32'h0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    count_window(10);
    sb_pop("clr_no_pulse", hi_cnt[0]);
    sb_pop("clr_no_tick", tick_cnt);
    rd(2, 32'h0, "clr_status");
    rd(3, 32'h0, "clr_pol");

    // Readback latency/hold and unmapped addresses.
    wr(9, 32'hABCD);
    rd(9, 32'hABCD, "duty5_rb");
    idle(2);
    check_val("rd_hold", rd_data, 32'hABCD);
    rd(12, 32'h0, "unmapped_rd");
    wr(13, 32'h55);
    rd(13, 32'h0, "unmapped_wr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
